// File: rtl/irq_onehot_arbiter.sv
// Round-robin interrupt arbiter: captures request lines into a pending
// register and holds a one-hot grant until the consumer acknowledges it.
module irq_onehot_arbiter #(
  parameter int N    = 8,
  parameter bit EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] req,
  input  logic         ack,
  input  logic         ovf_clr,
  output logic [N-1:0] grant,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic [N-1:0] overflow
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] req_q;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] ovf_q, ovf_d;
  logic [N-1:0] grant_q, grant_d;
  logic         valid_q, valid_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [N-1:0] cap, clr, ovf_set;
  logic [2:0]   sel, idx, gidx;
  logic         found, acc;

  assign acc = (state_q == GRANT) && enable && ack;
  assign clr = acc ? grant_q : '0;

  always_comb begin
    cap = '0;
    if (enable) cap = EDGE ? (req & ~req_q) : req;
  end

  // A capture on the line being acknowledged wins over its clear
  assign pend_d  = (pend_q & ~clr) | cap;
  assign ovf_set = EDGE ? (cap & pend_q & ~clr) : '0;
  assign ovf_d   = (ovf_clr ? '0 : ovf_q) | ovf_set;

  // Scan downward so the lowest offset from ptr is kept last
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr_q + 3'(k);
      if (pend_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++)
      if (grant_q[i]) gidx = 3'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (enable && found) state_d = GRANT;
      GRANT: if (!enable || ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (enable && found) begin
          grant_d = {{(N-1){1'b0}}, 1'b1} << sel;
          valid_d = 1'b1;
        end else begin
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!enable) begin
          grant_d = '0;
          valid_d = 1'b0;
        end else if (ack) begin
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = gidx + 3'd1;
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign grant    = grant_q;
  assign valid    = valid_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: doc/irq_onehot_arbiter.md
Name: irq_onehot_arbiter

Overview:
- Upstream stage of the 8-to-3 priority encoder. It captures eight request lines into a pending register and picks one pending line using round-robin.
- It presents the chosen line as a stable one-hot grant. The encoder converts that grant to a 3-bit index.
- The grant is held until the consumer acknowledges it, so the encoder input never changes while the index is being used.

Parameters:
- N, 8, number of request lines; fixed at 8 to match the encoder input width.
- EDGE, 1, capture mode: 1 = rising-edge capture, 0 = level capture.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  block enable; when 0, no capture and no grant.
- req  input  8  request lines; synchronous to clk.
- ack  input  1  consumer acknowledge; one-cycle pulse, meaningful only while valid=1.
- ovf_clr  input  1  pulse that clears all overflow flags.
- grant  output  8  one-hot grant, registered; 8'b0 when valid=0.
- valid  output  1  grant is valid, registered.
- pending  output  8  registered pending-request bits.
- overflow  output  8  sticky per-line lost-event flags.

Behaviour:
- Reset (rst_n=0, asynchronous): req_q, pending, grant, valid, overflow and ptr are all 0, and the state is IDLE.
- Edge detect:
  - req_q is req registered each cycle.
  - rise = req & ~req_q.
  - cap = rise when EDGE=1, and cap = req when EDGE=0.
- Capture, only when enable=1: pending[i] is set after any edge where cap[i]=1.
- Pending clear: on an accepted ack, pending[granted index] is cleared.
  - If cap is 1 on that same line in the same cycle, set wins and pending stays 1.
- Overflow, EDGE=1 only:
  - overflow[i] is set when cap[i]=1, pending[i] is already 1, and the bit is not being cleared this cycle.
  - ovf_clr clears all overflow bits; if a set and ovf_clr occur in the same cycle, set wins.
  - overflow stays 0 when EDGE=0.
- ptr is 3 bits. Round-robin selection picks the lowest index j, scanning ptr, ptr+1 and so on, wrapping modulo 8, with pending[j]=1.
- State machine, two states:
  - IDLE: if enable=1 and pending != 0, register grant = one-hot(j) and valid = 1, then go to GRANT. Otherwise grant=0 and valid=0.
  - GRANT: hold grant and valid unchanged until ack=1. On ack: clear pending[j], set ptr = (j+1) mod 8, set grant=0 and valid=0, then go to IDLE.
  - At least one IDLE cycle separates consecutive grants.
  - A new capture during GRANT never alters the current grant.
- Latency, EDGE=1: req rises and is sampled at edge k; pending[i]=1 after edge k; grant and valid are asserted after edge k+1, provided the block is IDLE with no other winner.
- ack while valid=0: ignored, with no effect on any state.
- enable deasserted:
  - Capture is blocked.
  - In GRANT, the block returns to IDLE at the next edge with grant=0 and valid=0.
  - pending and ptr are retained and no pending bit is cleared.
  - req_q keeps tracking req, so an edge that occurred while disabled is lost.
- Reset mid-GRANT: everything returns immediately to the reset values; the outstanding grant is discarded without any ack.
- Invariant: grant is always 0 or exactly one-hot, and valid = (grant != 0).

Test Plan:
- Reset, then enable=1 and req goes from 8'h00 to 8'h04 and stays high -> pending=8'h04 after 1 edge; grant=8'h04 and valid=1 after 2 edges; pulse ack -> grant=0, valid=0, pending=0, ptr=3.
- pending=8'h81 with ptr=0 -> grant order 8'h01 then, after ack, 8'h80; ptr wraps to 0 after the second ack.
- EDGE=1: while grant=8'h02 is held waiting for ack, line 1 pulses again -> overflow=8'h02 and grant unchanged. After ack, pending[1]=0; ovf_clr then gives overflow=0.
- A rising edge on line 5 in the same cycle as the ack of grant=8'h20 -> pending[5] stays 1 and line 5 is re-granted after the IDLE cycle, with no overflow.
- enable goes 1 to 0 during grant=8'h10 -> valid=0 next edge and pending=8'h10 retained. A req pulse on line 2 while disabled is not captured. Re-enable -> grant=8'h10 again.
- EDGE=0: hold req=8'h08 high -> repeated grants of 8'h08, each separated by one IDLE cycle after every ack; overflow stays 0. Assert rst_n=0 mid-grant -> all outputs 0 immediately.
